// File: rtl/maze_pkg.sv
// Shared maze definitions: arbiter state encodings, port IDs and grid constants
// used by the memory arbiter and the solver controller.
package maze_pkg;

    localparam int MAZE_ADDR_W = 8;
    localparam logic [MAZE_ADDR_W-1:0] MAZE_DEST = 8'hFF;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_DONE   = 2'd2
    } arbState_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

endpackage

// File: rtl/maze_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones once reached.
module maze_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Count register: clear wins over increment, increment stops at max
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt <= cnt;
        end
    end

endmodule

// File: rtl/maze_mem_arb.sv
// Round-robin arbiter sharing the 256x1 maze memory between the solver (A)
// and the host loader (B); one 3-cycle access at a time, A may lock out B.
module maze_mem_arb
    import maze_pkg::*;
#(
    parameter int ADDR_W = MAZE_ADDR_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic              wdata_a,
    input  logic              lock_a,
    output logic              ack_a,
    output logic              rdata_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic              wdata_b,
    output logic              ack_b,
    output logic              rdata_b,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wdata,
    input  logic              mem_rdata,
    output logic              busy,
    output logic [CNT_W-1:0]  gcnt_a,
    output logic [CNT_W-1:0]  gcnt_b
);

    arbState_t         state, stateNext;
    port_t             lastGrant, sel, pick;
    logic              grant, idleGrant, selWe;
    logic              cmdWe, cmdWdata;
    logic [ADDR_W-1:0] cmdAddr;

    // Round-robin pick; lock_a removes B from contention
    always_comb begin
        grant = 1'b0;
        pick  = PORT_A;
        if (req_a && req_b && !lock_a) begin
            grant = 1'b1;
            pick  = (lastGrant == PORT_A) ? PORT_B : PORT_A;
        end else if (req_a) begin
            grant = 1'b1;
            pick  = PORT_A;
        end else if (req_b && !lock_a) begin
            grant = 1'b1;
            pick  = PORT_B;
        end else begin
            grant = 1'b0;
            pick  = PORT_A;
        end
    end

    // Command of the winning port, captured only at the grant edge
    always_comb begin
        cmdWe    = 1'b0;
        cmdAddr  = '0;
        cmdWdata = 1'b0;
        if (pick == PORT_B) begin
            cmdWe    = we_b;
            cmdAddr  = addr_b;
            cmdWdata = wdata_b;
        end else begin
            cmdWe    = we_a;
            cmdAddr  = addr_a;
            cmdWdata = wdata_a;
        end
    end

    assign idleGrant = (state == ARB_IDLE) && grant;

    // Next-state logic: IDLE -> ACCESS -> DONE -> IDLE
    always_comb begin
        stateNext = state;
        case (state)
            ARB_IDLE: begin
                if (grant) begin
                    stateNext = ARB_ACCESS;
                end else begin
                    stateNext = ARB_IDLE;
                end
            end
            ARB_ACCESS: stateNext = ARB_DONE;
            ARB_DONE:   stateNext = ARB_IDLE;
            default:    stateNext = ARB_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Registered memory command, acks, read data and grant bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lastGrant <= PORT_B;
            sel       <= PORT_A;
            selWe     <= 1'b0;
            busy      <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 1'b0;
            ack_a     <= 1'b0;
            ack_b     <= 1'b0;
            rdata_a   <= 1'b0;
            rdata_b   <= 1'b0;
        end else begin
            busy      <= (stateNext != ARB_IDLE);
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 1'b0;
            ack_a     <= 1'b0;
            ack_b     <= 1'b0;
            if (idleGrant) begin
                sel       <= pick;
                lastGrant <= pick;
                selWe     <= cmdWe;
                mem_en    <= 1'b1;
                mem_we    <= cmdWe;
                mem_addr  <= cmdAddr;
                mem_wdata <= cmdWdata;
            end
            if (state == ARB_ACCESS) begin
                ack_a <= (sel == PORT_A);
                ack_b <= (sel == PORT_B);
            end
            // Memory read data is valid during DONE
            if ((state == ARB_DONE) && !selWe) begin
                if (sel == PORT_A) begin
                    rdata_a <= mem_rdata;
                end else begin
                    rdata_b <= mem_rdata;
                end
            end
        end
    end

    maze_sat_cnt #(.W(CNT_W)) u_cntA (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (idleGrant && (pick == PORT_A)),
        .cnt (gcnt_a)
    );

    maze_sat_cnt #(.W(CNT_W)) u_cntB (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (idleGrant && (pick == PORT_B)),
        .cnt (gcnt_b)
    );

endmodule
